// File: rtl/jzjpcc_mmio_pkg.sv
// ============================================================================
// Module  : jzjpcc_mmio_pkg
// Brief   : Shared types, constants and helpers for the MMIO bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package jzjpcc_mmio_pkg;

    typedef enum logic [1:0] {
        REG_IN   = 2'd0,
        REG_OUT  = 2'd1,
        REG_DIR  = 2'd2,
        REG_PEND = 2'd3
    } reg_sel_e;

    localparam int REGION_BYTES_PER_PORT = 16;

    // The bank occupies the topmost bytes of the 32-bit space, so its base is the two's complement of its size.
    function automatic logic [31:0] region_base(input int num_ports);
        return 32'd0 - 32'(REGION_BYTES_PER_PORT * num_ports);
    endfunction

    function automatic logic [31:0] expand_byte_mask(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/jzjpcc_mmio_bank_if.sv
// ============================================================================
// Module  : jzjpcc_mmio_bank_if
// Brief   : Memory-stage bus between the core and the MMIO bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface jzjpcc_mmio_bank_if;
    logic [29:0] memAddress;
    logic [3:0]  memByteMask;
    logic        memWriteEnable;
    logic [31:0] memDataToWrite;
    logic [31:0] memReadData;
    logic        memReadHit;

    modport master (
        output memAddress, memByteMask, memWriteEnable, memDataToWrite,
        input  memReadData, memReadHit
    );

    modport slave (
        input  memAddress, memByteMask, memWriteEnable, memDataToWrite,
        output memReadData, memReadHit
    );
endinterface

`default_nettype wire

// File: rtl/jzjpcc_mmio_port.sv
// ============================================================================
// Module  : jzjpcc_mmio_port
// Brief   : One MMIO port: input synchroniser, edge pending latch, OUT/DIR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jzjpcc_mmio_port #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        arm,
    input  wire logic [31:0] raw_in,
    input  wire logic        wr_out,
    input  wire logic        wr_dir,
    input  wire logic        wr_pend,
    input  wire logic [31:0] wr_bits,
    input  wire logic [31:0] wr_data,
    output logic      [31:0] in_sync,
    output logic      [31:0] out_reg,
    output logic      [31:0] dir_reg,
    output logic      [31:0] pend_reg,
    output logic             irq
);

    logic [31:0] prev;
    logic [31:0] rise;
    logic [31:0] clear_bits;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign in_sync = raw_in;
        end else begin : g_chain
            logic [SYNC_STAGES-1:0][31:0] chain;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    chain <= '0;
                end else begin
                    chain[0] <= raw_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign in_sync = chain[SYNC_STAGES-1];
        end
    endgenerate

    assign rise       = in_sync & ~prev;
    assign clear_bits = wr_pend ? (wr_data & wr_bits) : 32'd0;
    assign irq        = |pend_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            out_reg  <= '0;
            dir_reg  <= '0;
            pend_reg <= '0;
        end else begin
            prev <= in_sync;
            if (wr_out) out_reg <= (out_reg & ~wr_bits) | (wr_data & wr_bits);
            if (wr_dir) dir_reg <= (dir_reg & ~wr_bits) | (wr_data & wr_bits);
            // Set is OR-ed in after the clear so a simultaneous rise survives a W1C.
            pend_reg <= (pend_reg & ~clear_bits) | (arm ? rise : 32'd0);
        end
    end

endmodule

`default_nettype wire

// File: rtl/jzjpcc_mmio_bank.sv
// ============================================================================
// Module  : jzjpcc_mmio_bank
// Brief   : Parametrised MMIO bank: decode, read mux/register, edge arming.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jzjpcc_mmio_bank
    import jzjpcc_mmio_pkg::*;
#(
    parameter int NUM_PORTS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic                        clock,
    input  wire logic                        reset,
    jzjpcc_mmio_bank_if.slave                bus,
    input  wire logic [NUM_PORTS-1:0][31:0]  mmioInputs,
    output logic      [NUM_PORTS-1:0][31:0]  mmioOutputs,
    output logic      [NUM_PORTS-1:0][31:0]  mmioDirection,
    output logic      [NUM_PORTS-1:0]        mmioIrq
);

    localparam int          PB          = $clog2(NUM_PORTS);
    localparam int          IDX_W       = (PB > 0) ? PB : 1;
    localparam logic [31:0] REGION_BASE = region_base(NUM_PORTS);
    localparam logic [2:0]  ARM_MAX     = 3'(SYNC_STAGES + 1);

    logic              hit;
    logic              write_hit;
    logic [IDX_W-1:0]  port_idx;
    reg_sel_e          sel;
    logic [31:0]       wr_bits;
    logic [31:0]       rd_word;
    logic [2:0]        arm_cnt;
    logic              arm;

    logic [31:0] in_w   [NUM_PORTS];
    logic [31:0] pend_w [NUM_PORTS];

    assign hit       = {bus.memAddress, 2'b00} >= REGION_BASE;
    assign write_hit = hit & bus.memWriteEnable;
    assign sel       = reg_sel_e'(bus.memAddress[1:0]);
    assign wr_bits   = expand_byte_mask(bus.memByteMask);
    assign arm       = (arm_cnt == ARM_MAX);

    generate
        if (PB == 0) begin : g_idx_single
            assign port_idx = '0;
        end else begin : g_idx_multi
            assign port_idx = bus.memAddress[PB+1:2];
        end
    endgenerate

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
            logic sel_this;
            assign sel_this = write_hit && (port_idx == IDX_W'(g));

            jzjpcc_mmio_port #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_port (
                .clock    (clock),
                .reset    (reset),
                .arm      (arm),
                .raw_in   (mmioInputs[g]),
                .wr_out   (sel_this && (sel == REG_OUT)),
                .wr_dir   (sel_this && (sel == REG_DIR)),
                .wr_pend  (sel_this && (sel == REG_PEND)),
                .wr_bits  (wr_bits),
                .wr_data  (bus.memDataToWrite),
                .in_sync  (in_w[g]),
                .out_reg  (mmioOutputs[g]),
                .dir_reg  (mmioDirection[g]),
                .pend_reg (pend_w[g]),
                .irq      (mmioIrq[g])
            );
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_idx == IDX_W'(p)) begin
                case (sel)
                    REG_IN:   rd_word = in_w[p];
                    REG_OUT:  rd_word = mmioOutputs[p];
                    REG_DIR:  rd_word = mmioDirection[p];
                    REG_PEND: rd_word = pend_w[p];
                    default:  rd_word = '0;
                endcase
            end
        end
    end

    // Edge detection stays off until the synchroniser chain has flushed its reset zeros.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arm_cnt         <= '0;
            bus.memReadData <= '0;
            bus.memReadHit  <= 1'b0;
        end else begin
            if (!arm) arm_cnt <= arm_cnt + 3'd1;
            bus.memReadHit  <= hit;
            bus.memReadData <= hit ? rd_word : 32'd0;
        end
    end

endmodule

`default_nettype wire

// File: doc/jzjpcc_mmio_bank.md
Name: jzjpcc_mmio_bank

Overview:
Parametrised memory-mapped IO bank that replaces the fixed 8-in/8-out MMIO word array of the core.
- Provides NUM_PORTS ports, each with a synchronised input, an output register and a direction register.
- Adds rising-edge-pending latches (write-1-to-clear) and per-port interrupt lines.
- Sits beside the memory backend: the memory stage presents word address, byte mask and write data; the bank returns registered read data and a hit flag.

Parameters:
NUM_PORTS, 8, number of ports; power of 2, 1..64
SYNC_STAGES, 2, input synchroniser flops per bit, 0..3 (0 = input used directly)

Ports:
clock  input  1  core clock
reset  input  1  asynchronous, active-high
memAddress  input  30  word address [31:2] from memory stage
memByteMask  input  4  byte enables for writes
memWriteEnable  input  1  write strobe, qualified by region hit
memDataToWrite  input  32  write data
memReadData  output  32  registered read data
memReadHit  output  1  registered: previous-cycle address hit the region
mmioInputs  input  32 x NUM_PORTS  raw external inputs, possibly asynchronous
mmioOutputs  output  32 x NUM_PORTS  output registers
mmioDirection  output  32 x NUM_PORTS  direction registers (1 = drive), for external tristate logic
mmioIrq  output  NUM_PORTS  per-port OR of pending bits

Behaviour:
- Clock/reset: single clock domain on clock. reset is asynchronous, active-high.
- Region: top 16*NUM_PORTS bytes of the address space. Hit when memAddress[31:PB+4] is all ones, where PB = log2(NUM_PORTS). Port index = memAddress[PB+3:4]; register select = memAddress[3:2].
- Register map, per port:
  - 0 IN: read-only, synchronised input.
  - 1 OUT: read/write.
  - 2 DIR: read/write.
  - 3 PEND: read, write-1-to-clear.
- Writes (on the rising edge when memWriteEnable and hit):
  - Only bytes with memByteMask set are affected.
  - OUT and DIR: masked bytes take the new data.
  - PEND: masked bytes clear the bits that are 1 in the data.
  - IN: writes are ignored.
  - Writes with no hit are ignored.
- Reads:
  - memReadData and memReadHit update every edge from the current address; latency is 1 cycle.
  - No hit gives memReadData = 0 and memReadHit = 0.
  - Write and read to the same register in the same cycle returns the pre-write value.
- Synchroniser: each input bit passes through SYNC_STAGES flops. An input stable before edge k is readable in IN after edge k+SYNC_STAGES-1; with SYNC_STAGES = 0 it is visible combinationally.
- Edge detect:
  - prev holds the synchronised value delayed by one cycle.
  - rise = sync & ~prev.
  - pending |= rise at edge k+SYNC_STAGES.
  - If a set and a W1C clear hit the same bit on the same edge, set wins.
- Arming:
  - A counter blocks pending updates on the first SYNC_STAGES+1 edges after reset release. This prevents spurious edges from the reset value of the chain.
  - After that the counter saturates and detection stays enabled.
  - Reset asserted mid-operation re-zeroes the counter and re-blocks detection.
- mmioIrq[i] = |pending[i], combinational from the pending register.
- Reset values: all zero — mmioOutputs, mmioDirection, pending, synchroniser chain, prev, arm counter, memReadData, memReadHit.

Decomposition:
- Package jzjpcc_mmio_pkg holds:
  - register-select enum (IN, OUT, DIR, PEND);
  - REGION_BYTES_PER_PORT = 16;
  - a function computing the region base from NUM_PORTS.
- Sub-module jzjpcc_mmio_port: one port's synchroniser, prev, pending, OUT and DIR registers, and masked-write logic.
- The bank instantiates NUM_PORTS copies via generate and owns address decode, read mux, read register and arm counter.

Test Plan:
- Reset and defaults: reset, then read port 3 OUT (byte 0xFFFFFFB4, N=8) -> cycle later memReadData = 0, memReadHit = 1; all mmioOutputs, mmioDirection and mmioIrq = 0.
- Masked write: write 0xAABBCCDD, mask 4'b0101 to port 0 OUT (0xFFFFFF84) -> mmioOutputs[0] = 0x00BB00DD. Readback one cycle after the read is issued returns 0x00BB00DD.
- Input sync, SYNC_STAGES = 2: mmioInputs[5] goes 0 -> 0x1 before edge k.
  - IN reads 1 after edge k+1.
  - Pending[5] bit0 set at edge k+2; mmioIrq[5] = 1.
  - Write 0x1 to PEND clears it; mmioIrq[5] = 0.
- Set/clear collision: W1C of bit 0 on the same edge a new rise is detected -> bit stays 1.
- Arming: hold mmioInputs[2] = 0xFFFFFFFF through reset, then release -> pending[2] stays 0 and mmioIrq[2] stays 0 indefinitely.
- Out of region: write to 0xFFFFFF7C (N=8) -> no register changes; read returns memReadHit = 0, data 0. Repeat with NUM_PORTS = 1, SYNC_STAGES = 0: region is 0xFFFFFFF0..0xFFFFFFFC and a rise sets pending on the same edge.
